// File: rtl/axi4_lite_csr_master_if.sv
// AXI4-Lite bus bundle shared by CSR initiators and the filter CSR slaves.
interface axi4_lite_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4_lite_csr_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one bus transaction, one response out.
// Handshakes: a transfer happens on the rising edge where valid && ready; valid never drops before it.
module axi4_lite_csr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_wr_i,
  input  logic [ADDR_W-1:0]   cmd_addr_i,
  input  logic [DATA_W-1:0]   cmd_wdata_i,
  input  logic [DATA_W/8-1:0] cmd_wstrb_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic                rsp_wr_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  output logic [1:0]          rsp_resp_o,
  output logic                rsp_err_o,
  output logic [2:0]          dbg_state_o,
  axi4_lite_if.master         csr_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_WR_B = 3'd2,
    S_RD_A = 3'd3,
    S_RD_R = 3'd4,
    S_RSP  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                rsp_wr_q, rsp_wr_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  logic awvalid, wvalid, aw_hs, w_hs, aw_fin, w_fin, cmd_hs;

  // State register plus the command and response holding registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_wr_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign awvalid = (state_q == S_WR) && !aw_done_q;
  assign wvalid  = (state_q == S_WR) && !w_done_q;
  assign aw_hs   = awvalid && csr_o.awready;
  assign w_hs    = wvalid && csr_o.wready;
  // A channel counts as finished if it completed earlier or completes on this edge.
  assign aw_fin  = aw_done_q || aw_hs;
  assign w_fin   = w_done_q || w_hs;
  assign cmd_hs  = cmd_valid_i && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid_i)    state_d = cmd_wr_i ? S_WR : S_RD_A;
      S_WR:    if (aw_fin && w_fin) state_d = S_WR_B;
      S_WR_B:  if (csr_o.bvalid)   state_d = S_RSP;
      S_RD_A:  if (csr_o.arready)  state_d = S_RD_R;
      S_RD_R:  if (csr_o.rvalid)   state_d = S_RSP;
      S_RSP:   if (rsp_ready_i)    state_d = S_IDLE;
      default:                     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    if (cmd_hs) begin
      addr_d    = cmd_addr_i;
      wdata_d   = cmd_wdata_i;
      wstrb_d   = cmd_wstrb_i;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
    if (state_q == S_WR) begin
      aw_done_d = aw_fin;
      w_done_d  = w_fin;
    end
    if ((state_q == S_WR_B) && csr_o.bvalid) begin
      rsp_wr_d    = 1'b1;
      rsp_rdata_d = '0;
      rsp_resp_d  = csr_o.bresp;
    end
    if ((state_q == S_RD_R) && csr_o.rvalid) begin
      rsp_wr_d    = 1'b0;
      rsp_rdata_d = csr_o.rdata;
      rsp_resp_d  = csr_o.rresp;
    end
  end

  always_comb begin
    cmd_ready_o   = (state_q == S_IDLE);
    csr_o.awvalid = awvalid;
    csr_o.wvalid  = wvalid;
    csr_o.bready  = (state_q == S_WR_B);
    csr_o.arvalid = (state_q == S_RD_A);
    csr_o.rready  = (state_q == S_RD_R);
    rsp_valid_o   = (state_q == S_RSP);
    csr_o.awaddr  = addr_q;
    csr_o.araddr  = addr_q;
    csr_o.wdata   = wdata_q;
    csr_o.wstrb   = wstrb_q;
    csr_o.awprot  = 3'b000;
    csr_o.arprot  = 3'b000;
    rsp_wr_o      = rsp_wr_q;
    rsp_rdata_o   = rsp_rdata_q;
    rsp_resp_o    = rsp_resp_q;
    rsp_err_o     = (rsp_resp_q != 2'b00);
    dbg_state_o   = state_q;
  end

endmodule

// File: tb/tb_axi4_lite_csr_master.sv
// Bench for axi4_lite_csr_master: stub CSR slave with programmable delays and a response scoreboard.
module tb_axi4_lite_csr_master;
  localparam int W = 35;  // {wr, rdata[31:0], resp[1:0]}

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_wr_i    = 1'b0;
  logic [31:0] cmd_addr_i  = '0;
  logic [31:0] cmd_wdata_i = '0;
  logic [3:0]  cmd_wstrb_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic        rsp_wr_o;
  logic [31:0] rsp_rdata_o;
  logic [1:0]  rsp_resp_o;
  logic        rsp_err_o;
  logic [2:0]  dbg_state_o;

  axi4_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  axi4_lite_csr_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_wr_i(cmd_wr_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wstrb_i(cmd_wstrb_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_wr_o(rsp_wr_o),
    .rsp_rdata_o(rsp_rdata_o), .rsp_resp_o(rsp_resp_o), .rsp_err_o(rsp_err_o),
    .dbg_state_o(dbg_state_o), .csr_o(bus)
  );

  // ---------------- stub CSR slave ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic        cfg_force = 1'b0;
  logic [31:0] cfg_rdata = '0;

  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic [31:0] s_reg, s_awaddr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        aw_got, w_got;

  assign bus.awready = bus.awvalid && (aw_cnt >= aw_dly);
  assign bus.wready  = bus.wvalid  && (w_cnt  >= w_dly);
  assign bus.arready = bus.arvalid && (ar_cnt >= ar_dly);

  always @(posedge clk_i or posedge rst_i) begin
    logic        aw_now, w_now;
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    if (rst_i) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      s_reg <= 32'h0000_0001;
      s_awaddr <= '0; s_wdata <= '0; s_wstrb <= '0;
      aw_got <= 1'b0; w_got <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
    end else begin
      aw_cnt <= (bus.awvalid && !bus.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.wvalid  && !bus.wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (bus.arvalid && !bus.arready) ? ar_cnt + 1 : 0;
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      wa = aw_now ? bus.awaddr : s_awaddr;
      wd = w_now ? bus.wdata : s_wdata;
      ws = w_now ? bus.wstrb : s_wstrb;
      if (bus.bvalid && bus.bready) bus.bvalid <= 1'b0;
      if ((aw_got || aw_now) && (w_got || w_now)) begin
        aw_got <= 1'b0; w_got <= 1'b0;
        bus.bvalid <= 1'b1; bus.bresp <= cfg_bresp;
        if (wa == 32'h0)
          for (int b = 0; b < 4; b++) if (ws[b]) s_reg[8*b +: 8] <= wd[8*b +: 8];
      end else begin
        if (aw_now) begin aw_got <= 1'b1; s_awaddr <= bus.awaddr; end
        if (w_now) begin w_got <= 1'b1; s_wdata <= bus.wdata; s_wstrb <= bus.wstrb; end
      end
      if (bus.rvalid && bus.rready) bus.rvalid <= 1'b0;
      if (bus.arvalid && bus.arready) begin
        r_cnt <= r_dly;
        bus.rvalid <= (r_dly == 0);
        bus.rresp <= cfg_rresp;
        bus.rdata <= cfg_force ? cfg_rdata : ((bus.araddr == 32'h0) ? s_reg : 32'h0);
      end else if (r_cnt > 0) begin
        r_cnt <= r_cnt - 1;
        if (r_cnt == 1) bus.rvalid <= 1'b1;
      end
    end
  end

  // ---------------- bus monitor ----------------
  int          aw_cyc = 0, w_cyc = 0, b_hs = 0, rsp_hs = 0, w_unstable = 0;
  logic        prev_wpend = 1'b0;
  logic [31:0] prev_wdata = '0;
  always @(posedge clk_i) begin
    if (bus.awvalid) aw_cyc <= aw_cyc + 1;
    if (bus.wvalid) w_cyc <= w_cyc + 1;
    if (bus.bvalid && bus.bready) b_hs <= b_hs + 1;
    if (rsp_valid_o && rsp_ready_i) rsp_hs <= rsp_hs + 1;
    if (prev_wpend && bus.wvalid && (bus.wdata !== prev_wdata)) w_unstable <= w_unstable + 1;
    prev_wpend <= bus.wvalid && !bus.wready;
    prev_wdata <= bus.wdata;
  end

  // ---------------- scoreboard / checking ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0, n_fail = 0;
  logic [31:0] mdl_reg = 32'h0000_0001;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_rdata,
                          input logic [1:0] exp_resp, output int waits);
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_wr_i = wr; cmd_addr_i = addr;
    cmd_wdata_i = wdata; cmd_wstrb_i = strb;
    waits = 0;
    while (!cmd_ready_o && waits < 200) begin
      @(negedge clk_i);
      waits++;
    end
    if (waits >= 200) check_eq("cmd_accept_timeout", 1, 0);
    exp_q.push_back({wr, (wr ? 32'h0 : exp_rdata), exp_resp});
    if (wr && addr == 32'h0)
      for (int b = 0; b < 4; b++) if (strb[b]) mdl_reg[8*b +: 8] = wdata[8*b +: 8];
    @(posedge clk_i);
    #1;
    // Scramble the command bus after acceptance; the DUT must not follow it.
    cmd_valid_i = 1'b0; cmd_wr_i = ~wr; cmd_addr_i = $urandom;
    cmd_wdata_i = $urandom; cmd_wstrb_i = 4'($urandom_range(0, 15));
  endtask

  task automatic get_rsp(input int stall, output int lat);
    logic [W:0]   snap;
    logic [W-1:0] exp;
    int unst, rdy_hi;
    lat = 0; unst = 0; rdy_hi = 0;
    @(negedge clk_i);
    while (!rsp_valid_o && lat < 200) begin
      @(negedge clk_i);
      lat++;
    end
    if (lat >= 200) begin
      check_eq("rsp_timeout", 1, 0);
      return;
    end
    snap = {rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o};
    for (int i = 0; i < stall; i++) begin
      if (cmd_ready_o) rdy_hi++;
      @(negedge clk_i);
      if (!rsp_valid_o || ({rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o} !== snap)) unst++;
    end
    if (cmd_ready_o) rdy_hi++;
    if (stall > 0) begin
      check_eq("rsp_stable_stall", unst, 0);
      check_eq("cmd_ready_in_rsp", rdy_hi, 0);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    rsp_ready_i = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("sb_unexpected_rsp", 1, 0);
      return;
    end
    exp = exp_q.pop_front();
    check_eq("rsp_payload", snap[W:1], exp);
    check_eq("rsp_err", snap[0], (exp[1:0] != 2'b00));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int waits, lat, aw0, w0, b0, r0, u0;
    logic wr;
    logic [31:0] addr, data;
    logic [1:0] resp;

    repeat (3) @(negedge clk_i);
    check_eq("rst_cmd_ready", cmd_ready_o, 1);
    check_eq("rst_state", dbg_state_o, 0);
    check_eq("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready, rsp_valid_o}, 0);
    check_eq("rst_addr_data", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 0);
    check_eq("rst_prot", {bus.awprot, bus.arprot}, 0);
    check_eq("rst_rsp", {rsp_wr_o, rsp_rdata_o, rsp_resp_o, rsp_err_o}, 0);
    rst_i = 1'b0;

    // Enable register reads back its reset value.
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mdl_reg, 2'b00, waits);
    get_rsp(0, lat);
    check_eq("rd_latency", lat, 2);

    // Write 0 to the enable register, then read it back.
    aw0 = aw_cyc; w0 = w_cyc;
    send_cmd(1'b1, 32'h0, 32'h0, 4'hF, 32'h0, 2'b00, waits);
    get_rsp(0, lat);
    check_eq("wr_latency", lat, 2);
    check_eq("wr_aw_cycles", aw_cyc - aw0, 1);
    check_eq("wr_w_cycles", w_cyc - w0, 1);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mdl_reg, 2'b00, waits);
    get_rsp(0, lat);

    // wready lags awready by 3 cycles.
    w_dly = 3;
    aw0 = aw_cyc; w0 = w_cyc; b0 = b_hs; r0 = rsp_hs; u0 = w_unstable;
    send_cmd(1'b1, 32'h10, 32'hA5A5_5A5A, 4'hF, 32'h0, 2'b00, waits);
    get_rsp(0, lat);
    repeat (3) @(negedge clk_i);
    check_eq("wdly_aw_cycles", aw_cyc - aw0, 1);
    check_eq("wdly_w_cycles", w_cyc - w0, 4);
    check_eq("wdly_wdata_stable", w_unstable - u0, 0);
    check_eq("wdly_b_count", b_hs - b0, 1);
    check_eq("wdly_rsp_count", rsp_hs - r0, 1);
    w_dly = 0;

    // Slow read returning SLVERR.
    ar_dly = 5; r_dly = 2; cfg_force = 1'b1; cfg_rdata = 32'hDEAD_BEEF; cfg_rresp = 2'b10;
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b10, waits);
    get_rsp(0, lat);
    check_eq("slow_rd_latency", lat, 9);
    ar_dly = 0; r_dly = 0; cfg_force = 1'b0; cfg_rresp = 2'b00;

    // Response back-pressure with a command waiting.
    send_cmd(1'b1, 32'h0, 32'h1234_5678, 4'h3, 32'h0, 2'b00, waits);
    @(negedge clk_i);
    cmd_valid_i = 1'b1; cmd_wr_i = 1'b0; cmd_addr_i = 32'h0;
    get_rsp(10, lat);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mdl_reg, 2'b00, waits);
    check_eq("cmd_after_rsp_wait", waits, 0);
    get_rsp(0, lat);

    // Random mix of reads and writes with random slave timing and responses.
    for (int i = 0; i < 8; i++) begin
      aw_dly = $urandom_range(0, 3); w_dly = $urandom_range(0, 3);
      ar_dly = $urandom_range(0, 3); r_dly = $urandom_range(0, 3);
      wr = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 1) == 1) ? 32'h4 : 32'h0;
      data = $urandom;
      resp = 2'($urandom_range(0, 3));
      cfg_bresp = resp; cfg_rresp = resp;
      send_cmd(wr, addr, data, 4'($urandom_range(0, 15)),
               (addr == 32'h0) ? mdl_reg : 32'h0, resp, waits);
      get_rsp($urandom_range(0, 2), lat);
    end
    cfg_bresp = 2'b00; cfg_rresp = 2'b00;

    // Reset while the write address is still waiting.
    aw_dly = 6; w_dly = 6;
    send_cmd(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00, waits);
    @(negedge clk_i);
    @(negedge clk_i);
    check_eq("mid_wr_awvalid", bus.awvalid, 1);
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_valids", {bus.awvalid, bus.wvalid, rsp_valid_o}, 0);
    check_eq("mid_rst_cmd_ready", cmd_ready_o, 1);
    exp_q.delete();
    mdl_reg = 32'h0000_0001;
    aw_dly = 0; w_dly = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    check_eq("post_rst_cmd_ready", cmd_ready_o, 1);
    send_cmd(1'b0, 32'h0, 32'h0, 4'h0, mdl_reg, 2'b00, waits);
    get_rsp(0, lat);
    check_eq("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi4_lite_csr_master.md
Name: axi4_lite_csr_master

Overview:
- Single-outstanding AXI4-Lite initiator. Converts a simple valid/ready command port into AXI4-Lite write or read transactions on an axi4_lite_if master port.
- Returns one response per command.
- Sits between control sequencers or test drivers and the filter CSR slaves of the image processing pipeline, such as the median filter enable register.

Parameters:
- ADDR_W, 32, width of cmd_addr_i and the AXI address channels.
- DATA_W, 32, data width; fixed at 32 for AXI4-Lite; wstrb width is DATA_W/8.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- cmd_valid_i  input  1  command valid
- cmd_ready_o  output  1  command accepted when high with cmd_valid_i
- cmd_wr_i  input  1  1 = write, 0 = read
- cmd_addr_i  input  ADDR_W  byte address
- cmd_wdata_i  input  DATA_W  write data (ignored for reads)
- cmd_wstrb_i  input  DATA_W/8  byte strobes (ignored for reads)
- rsp_valid_o  output  1  response valid
- rsp_ready_i  input  1  response consumed
- rsp_wr_o  output  1  response belongs to a write
- rsp_rdata_o  output  DATA_W  read data; 0 for writes
- rsp_resp_o  output  2  bresp or rresp as received
- rsp_err_o  output  1  rsp_resp_o != 2'b00
- csr_o  axi4_lite_if.master  -  AXI4-Lite bus to the slave

Behaviour:
- Reset: state IDLE. cmd_ready_o=1. awvalid, wvalid, arvalid, bready, rready, rsp_valid_o all 0. awaddr, araddr, wdata, wstrb, rsp_* all 0. awprot and arprot are tied 3'b000.
- Command acceptance:
  - cmd_ready_o = (state==IDLE), combinational from state only.
  - Handshake cmd_valid_i && cmd_ready_o latches addr, wdata, wstrb and wr into registers.
  - Later changes on cmd_* have no effect until the next acceptance.
- States: IDLE, WR, WR_B, RD_A, RD_R, RSP.
- IDLE:
  - On a write cmd handshake → WR; awvalid and wvalid both rise on the next cycle (one-cycle latency).
  - On a read cmd handshake → RD_A; arvalid rises on the next cycle.
- WR: the AW and W channels are tracked independently by aw_done and w_done flags.
  - awvalid deasserts the cycle after awvalid && awready. wvalid deasserts the cycle after wvalid && wready.
  - Either channel may complete first, or both may complete in the same cycle.
  - When both are done (both flags set, or the last pending handshake occurs this cycle) → WR_B with bready=1.
  - Valid, address and data stay stable while waiting for ready; AXI rule: valid is never withdrawn before its handshake.
- WR_B:
  - bready=1. On bvalid, capture bresp into rsp_resp_o, set rsp_wr_o=1 and rsp_rdata_o=0.
  - In the same edge, bready→0 and state → RSP.
- RD_A: arvalid held with araddr stable until arready; then arvalid→0, rready→1, state → RD_R.
- RD_R:
  - rready=1. On rvalid, capture rdata and rresp, set rsp_wr_o=0.
  - rready→0, state → RSP.
- RSP:
  - rsp_valid_o=1, with payload stable until rsp_ready_i.
  - On the handshake, rsp_valid_o→0 and state → IDLE. The next command can be accepted in the following cycle, not the same cycle.
- Minimum command-to-response latency with an always-ready slave:
  - Write: cmd edge; AW/W handshake +1; B captured once bvalid appears; rsp_valid_o high the cycle after B.
  - Read: ar at +1; rsp_valid_o the cycle after the R handshake.
- Only one transaction is outstanding; no AW/AR overlap is ever issued.
- bvalid or rvalid arriving outside WR_B/RD_R is ignored, since bready and rready are 0 there.
- rsp_err_o is combinational from the registered rsp_resp_o.
- Reset mid-transaction:
  - All outputs return to reset values immediately (asynchronous); the in-flight transaction is abandoned.
  - The system resets the slave together with the master.

Test Plan:
- Write 0x0000_0000 ← 0x0000_0000, wstrb 4'hF, to the median filter CSR slave (BASE_ADDR 0) → AW and W issued together; bresp=00; rsp_valid_o with rsp_wr_o=1, rsp_err_o=0. A following read of 0x0 returns rsp_rdata_o=0x0000_0000.
- Read 0x0 right after reset on the same slave → rsp_rdata_o=0x0000_0001 (enable reset value), rsp_resp_o=00.
- Stub slave with wready delayed 3 cycles after awready → awvalid drops after 1 cycle; wvalid stays high with wdata stable for 3 more cycles; exactly one B accepted; exactly one response.
- Stub slave with arready delayed 5 cycles and rvalid 2 cycles later, returning rresp=2'b10, rdata=0xDEAD_BEEF → rsp_rdata_o=0xDEADBEEF, rsp_resp_o=10, rsp_err_o=1.
- rsp_ready_i held low 10 cycles → rsp_valid_o and payload stable; cmd_ready_o stays 0 and a pending cmd_valid_i is not accepted until the cycle after the response handshake.
- Assert rst_i while in WR with awvalid=1 → awvalid, wvalid and rsp_valid_o are 0 during reset; after release cmd_ready_o=1 and a fresh read completes normally.
